branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters (power of two, 4..64).
REQ-002 SHALL have parameter XLEN, default 32, PC/target width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port f_pc  input  XLEN  fetch-stage PC for prediction lookup.
REQ-006 SHALL have port f_pred_taken  output  1  prediction for f_pc, combinational.
REQ-007 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-008 SHALL have port ex_branch  input  1  EX instruction is conditional branch.
REQ-009 SHALL have port ex_jump  input  1  EX instruction is JAL/JALR.
REQ-010 SHALL have port ex_taken  input  1  comparator result for EX branch.
REQ-011 SHALL have port ex_pred_taken  input  1  prediction piped down with EX instruction.
REQ-012 SHALL have ports ex_pc, ex_target  input  XLEN  EX instruction PC and computed target.
REQ-013 SHALL have port redir_valid  output  1  redirect request to fetch.
REQ-014 SHALL have port redir_pc  output  XLEN  redirect address, registered.
REQ-015 SHALL have port redir_ready  input  1  fetch accepts redirect.
REQ-016 SHALL have port flush  output  1  kill IF/ID and ID/EX contents.
REQ-017 SHALL have port stall  output  1  freeze PC and IF/ID.

Function
REQ-018 SHALL implement FSM states IDLE, REDIR, DRAIN.
REQ-019 SHALL, in IDLE, resolve when ex_valid & (ex_branch | ex_jump): actual = ex_jump | ex_taken; mispredict = actual != ex_pred_taken.
REQ-020 SHALL treat ex_branch & ex_jump both high as jump.
REQ-021 SHALL, on mispredict in IDLE, assert flush combinationally that cycle, load redir_pc with actual ? ex_target : ex_pc+4 (bit 0 forced 0, wrap modulo 2^XLEN), and enter REDIR next edge.
REQ-022 SHALL, in REDIR, drive redir_valid=1, flush=1, stall=1, hold redir_pc stable until redir_valid & redir_ready.
REQ-023 SHALL, on handshake in REDIR, enter DRAIN; redir_valid deasserts next cycle.
REQ-024 SHALL, in DRAIN, drive flush=1, stall=0, redir_valid=0 for exactly one cycle, then return to IDLE.
REQ-025 SHALL ignore all ex_* inputs in REDIR and DRAIN (no resolution, no predictor update).
REQ-026 SHALL drive flush=0, stall=0, redir_valid=0 in IDLE without mispredict; correctly predicted branches cause no bubble.
REQ-027 SHALL give minimum mispredict penalty of 3 cycles (detect, REDIR with ready=1, DRAIN).

Reset
REQ-028 SHALL, on rst low, asynchronously force state IDLE, redir_valid=0, redir_pc=0, flush=0, stall=0, all predictor counters to 2'b01.
REQ-029 SHALL abandon any pending redirect when reset asserts mid-REDIR; no redirect after release.

Configuration
REQ-030 SHALL compile the predictor only when macro BRANCH_PREDICT_EN is defined.
REQ-031 SHALL, with BRANCH_PREDICT_EN, index counters by pc[log2(BHT_ENTRIES)+1:2]; f_pred_taken = counter[1].
REQ-032 SHALL, with BRANCH_PREDICT_EN, update counter at ex_pc index on each IDLE resolution of a conditional branch: saturating +1 if ex_taken, -1 otherwise (saturate at 3 and 0); jumps do not update.
REQ-033 SHALL return the pre-update value when f_pc and ex_pc index the same entry in the update cycle.
REQ-034 SHALL, without BRANCH_PREDICT_EN, tie f_pred_taken=0 (static not-taken) with no counter storage; FSM unchanged.

Verification
REQ-035 Bench SHALL: BEQ at ex_pc=0x100, ex_taken=1, ex_pred_taken=0, target 0x080, redir_ready=1 -> flush same cycle, redir_valid/redir_pc=0x080 next cycle, DRAIN flush one cycle, IDLE after 3 cycles.
REQ-036 Bench SHALL: BNE ex_taken=0, ex_pred_taken=1, ex_pc=0xFFFFFFFC -> redir_pc=0x00000000 (wrap).
REQ-037 Bench SHALL: mispredict with redir_ready low 4 cycles -> redir_valid, stall, flush held, redir_pc stable 4 cycles, DRAIN after ready.
REQ-038 Bench SHALL: JALR target 0x203, ex_pred_taken=0 -> redir_pc=0x202; no predictor update.
REQ-039 Bench SHALL (BRANCH_PREDICT_EN): three taken resolutions at ex_pc=0x40 -> f_pc=0x40 prediction 0,1,1 after each; counter saturates at 3; undefined macro -> always 0.
REQ-040 Bench SHALL: rst low during REDIR -> redir_valid, flush, stall 0 immediately; no redirect after release.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Resolves EX-stage branches/jumps, raises a redirect to fetch on a
// misprediction and sequences the pipeline flush (IDLE -> REDIR -> DRAIN).
// Optional 2-bit saturating-counter direction predictor, compiled in only
// when the macro BRANCH_PREDICT_EN is defined; otherwise static not-taken.
module branch_redirect_ctrl #(
   parameter int BHT_ENTRIES = 16,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] f_pc,
   output logic            f_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jump,
   input  logic            ex_taken,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   input  logic            redir_ready,
   output logic            flush,
   output logic            stall
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REDIR = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_redir_pc;
   logic [XLEN-1:0] w_redir_target;
   logic            w_resolve;
   logic            w_actual;
   logic            w_mispredict;
   logic            w_load_pc;
   logic            w_flush;
   logic            w_stall;
   logic            w_redir_valid;

   // Resolution only counts while out of reset so flush stays low during rst.
   assign w_resolve      = rst & ex_valid & (ex_branch | ex_jump);
   // A jump is always taken; branch+jump together behaves as a jump.
   assign w_actual       = ex_jump | ex_taken;
   assign w_mispredict   = w_resolve & (w_actual != ex_pred_taken);
   assign w_redir_target = w_actual ? ex_target : (ex_pc + XLEN'(4));

   // State register: async reset abandons any pending redirect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control outputs; misprediction flush is same-cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_flush       = 1'b0;
      w_stall       = 1'b0;
      w_redir_valid = 1'b0;
      w_load_pc     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_mispredict) begin
               w_flush     = 1'b1;
               w_load_pc   = 1'b1;
               w_state_nxt = ST_REDIR;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REDIR: begin
            w_redir_valid = 1'b1;
            w_flush       = 1'b1;
            w_stall       = 1'b1;
            if (redir_ready) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_REDIR;
            end
         end
         ST_DRAIN: begin
            w_flush     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Redirect address capture; bit 0 cleared so JALR targets are aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_redir_pc <= {XLEN{1'b0}};
      end else if (w_load_pc) begin
         r_redir_pc <= {w_redir_target[XLEN-1:1], 1'b0};
      end else begin
         r_redir_pc <= r_redir_pc;
      end
   end

   assign redir_pc    = r_redir_pc;
   assign redir_valid = w_redir_valid;
   assign flush       = w_flush;
   assign stall       = w_stall;

`ifdef BRANCH_PREDICT_EN
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   // Saturating 2-bit counter step: up on taken, down on not-taken.
   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
      logic [1:0] res;
      res = cnt;
      if (up) begin
         if (cnt != 2'b11) begin
            res = cnt + 2'b01;
         end else begin
            res = cnt;
         end
      end else begin
         if (cnt != 2'b00) begin
            res = cnt - 2'b01;
         end else begin
            res = cnt;
         end
      end
      return res;
   endfunction

   logic [1:0]       r_bht [BHT_ENTRIES];
   logic [IDX_W-1:0] w_f_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic             w_bht_upd;
   logic             w_unused_f_pc;

   assign w_f_idx       = f_pc[IDX_W+1:2];
   assign w_ex_idx      = ex_pc[IDX_W+1:2];
   assign w_unused_f_pc = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};
   // Only conditional branches resolved in IDLE train the table.
   assign w_bht_upd     = (r_state == ST_IDLE) & w_resolve & ex_branch & ~ex_jump;
   // Array read returns the pre-update value on a same-entry collision.
   assign f_pred_taken  = r_bht[w_f_idx][1];

   // Predictor table: weakly-not-taken after reset, trained on resolution.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (w_bht_upd) begin
         r_bht[w_ex_idx] <= sat_step(r_bht[w_ex_idx], ex_taken);
      end else begin
         r_bht[w_ex_idx] <= r_bht[w_ex_idx];
      end
   end
`else
   logic w_unused_f_pc;

   assign w_unused_f_pc = ^f_pc;
   // Static not-taken prediction.
   assign f_pred_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: stimulus pushes the expected
// redirect address; a forked monitor pops/compares at each handshake.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic        ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken;
   logic [31:0] ex_pc, ex_target;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        redir_ready;
   logic        flush, stall;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   branch_redirect_ctrl #(.BHT_ENTRIES(16), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
      .ex_pc(ex_pc), .ex_target(ex_target),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
      .flush(flush), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input string name, input logic fl, input logic st, input logic rv);
      chk({name, "_flush"}, {31'd0, flush}, {31'd0, fl});
      chk({name, "_stall"}, {31'd0, stall}, {31'd0, st});
      chk({name, "_redir_valid"}, {31'd0, redir_valid}, {31'd0, rv});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic ex_drive(input logic br, input logic jp, input logic tk, input logic pr,
                           input logic [31:0] pc, input logic [31:0] tgt);
      ex_valid = 1'b1; ex_branch = br; ex_jump = jp; ex_taken = tk;
      ex_pred_taken = pr; ex_pc = pc; ex_target = tgt;
   endtask

   task automatic ex_clear();
      ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_taken = 1'b0;
      ex_pred_taken = 1'b0; ex_pc = 32'd0; ex_target = 32'd0;
   endtask

   // Scoreboard monitor: every accepted redirect must match the oldest expectation.
   task automatic sb_monitor();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (redir_valid === 1'b1 && redir_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_redirect actual=%h required=none", redir_pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_redir_pc", redir_pc, e);
            end
         end
      end
   endtask

   // Fast mispredict sequence with ready high: detect, REDIR, DRAIN, IDLE.
   task automatic fast_redirect(input string name, input logic br, input logic jp,
                                input logic tk, input logic pr, input logic [31:0] pc,
                                input logic [31:0] tgt, input logic [31:0] exp_pc);
      cyc();
      redir_ready = 1'b1;
      ex_drive(br, jp, tk, pr, pc, tgt);
      exp_q.push_back(exp_pc);
      samp(); chk_ctl({name, "_detect"}, 1'b1, 1'b0, 1'b0);
      cyc(); ex_clear();
      samp(); chk_ctl({name, "_redir"}, 1'b1, 1'b1, 1'b1);
      chk({name, "_redir_pc"}, redir_pc, exp_pc);
      cyc();
      samp(); chk_ctl({name, "_drain"}, 1'b1, 1'b0, 1'b0);
      cyc();
      samp(); chk_ctl({name, "_idle"}, 1'b0, 1'b0, 1'b0);
   endtask

   int pred_exp[7];

   initial begin
      fork
         sb_monitor();
      join_none

      rst = 1'b0; f_pc = 32'd0; redir_ready = 1'b0;
      ex_clear();
      samp(); samp();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_redir_pc", redir_pc, 32'd0);
      chk("reset_pred", {31'd0, f_pred_taken}, 32'd0);
      rst = 1'b1;

      // BEQ taken, predicted not-taken: redirect to target.
      fast_redirect("beq", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0080);
      // BNE not taken, predicted taken at top of memory: pc+4 wraps to 0.
      fast_redirect("bne_wrap", 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 32'h0000_0000);

      // Mispredict with ready held low four REDIR cycles; ex_* must be ignored.
      cyc();
      redir_ready = 1'b0;
      ex_drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_03C4);
      exp_q.push_back(32'h0000_03C4);
      samp(); chk_ctl("hold_detect", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         ex_drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0700);
         samp(); chk_ctl("hold_wait", 1'b1, 1'b1, 1'b1);
         chk("hold_redir_pc", redir_pc, 32'h0000_03C4);
      end
      cyc(); redir_ready = 1'b1;
      samp(); chk_ctl("hold_accept", 1'b1, 1'b1, 1'b1);
      cyc(); redir_ready = 1'b0;
      samp(); chk_ctl("hold_drain", 1'b1, 1'b0, 1'b0);
      cyc(); ex_clear();
      samp(); chk_ctl("hold_idle", 1'b0, 1'b0, 1'b0);
      cyc();
      samp(); chk_ctl("hold_idle2", 1'b0, 1'b0, 1'b0);

      // JALR to odd target: bit 0 cleared, no predictor training.
      fast_redirect("jalr", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0084, 32'h0000_0203, 32'h0000_0202);
      f_pc = 32'h0000_0084;
      samp(); chk("jalr_no_update", {31'd0, f_pred_taken}, 32'd0);
      // Branch and jump both high behaves as a jump even with ex_taken low.
      fast_redirect("br_and_jmp", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0088, 32'h0000_1234, 32'h0000_1234);

      // Reset asserted while REDIR waits: everything drops at once.
      cyc();
      redir_ready = 1'b0;
      ex_drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0380);
      samp(); chk_ctl("rstmid_detect", 1'b1, 1'b0, 1'b0);
      cyc(); ex_clear();
      samp(); chk_ctl("rstmid_redir", 1'b1, 1'b1, 1'b1);
      #2 rst = 1'b0;
      #1 chk_ctl("rstmid_async", 1'b0, 1'b0, 1'b0);
      chk("rstmid_redir_pc", redir_pc, 32'd0);
      samp(); samp();
      rst = 1'b1;
      redir_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         samp(); chk_ctl("rstmid_after", 1'b0, 1'b0, 1'b0);
      end

      // Predictor training at 0x40 with correct predictions (no bubbles).
`ifdef BRANCH_PREDICT_EN
      pred_exp = '{0, 1, 1, 1, 1, 1, 0};
`else
      pred_exp = '{0, 0, 0, 0, 0, 0, 0};
`endif
      f_pc = 32'h0000_0040;
      for (int i = 0; i < 6; i++) begin
         cyc();
         ex_drive(1'b1, 1'b0, (i < 4), (i < 4), 32'h0000_0040, 32'h0000_0010);
         samp();
         chk("pred_0x40", {31'd0, f_pred_taken}, pred_exp[i]);
         chk_ctl("pred_nobubble", 1'b0, 1'b0, 1'b0);
      end
      cyc(); ex_clear();
      samp(); chk("pred_0x40_final", {31'd0, f_pred_taken}, pred_exp[6]);
      f_pc = 32'h0000_0044;
      samp(); chk("pred_other_idx", {31'd0, f_pred_taken}, 32'd0);

      cyc(); cyc();
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
